// File: rtl/operand_fetch_stage.sv
// Operand fetch: per-thread scalar/vector register files with registered reads,
// followed by combinational operand, mask and store-value selection.
package operand_fetch_pkg;
    localparam int THREADS_PER_CORE = 4;

    typedef logic [$clog2(THREADS_PER_CORE)-1:0] thread_idx_t;
    typedef logic [4:0]                          register_idx_t;
    typedef logic [3:0]                          subcycle_t;

    typedef enum logic [1:0] {
        OP2_SCALAR2   = 2'd0,
        OP2_VECTOR2   = 2'd1,
        OP2_IMMEDIATE = 2'd2
    } op2_src_t;

    typedef enum logic [1:0] {
        MASK_SCALAR1  = 2'd0,
        MASK_SCALAR2  = 2'd1,
        MASK_ALL_ONES = 2'd2
    } mask_src_t;

    typedef struct packed {
        logic [31:0]   pc;
        register_idx_t scalar_sel1;
        register_idx_t scalar_sel2;
        register_idx_t vector_sel1;
        register_idx_t vector_sel2;
        logic          op1_is_vector;
        op2_src_t      op2_src;
        mask_src_t     mask_src;
        logic          store_value_is_vector;
        logic [31:0]   immediate_value;
    } decoded_instruction_t;
endpackage

module operand_fetch_stage
    import operand_fetch_pkg::*;
#(
    parameter int THREADS       = THREADS_PER_CORE,
    parameter int NUM_REGISTERS = 32,
    parameter int NUM_LANES     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ts_instruction_valid,
    input  decoded_instruction_t      ts_instruction,
    input  thread_idx_t               ts_thread_idx,
    input  subcycle_t                 ts_subcycle,
    input  logic                      wb_writeback_en,
    input  thread_idx_t               wb_writeback_thread_idx,
    input  logic                      wb_writeback_is_vector,
    input  register_idx_t             wb_writeback_reg,
    input  logic [32*NUM_LANES-1:0]   wb_writeback_value,
    input  logic [NUM_LANES-1:0]      wb_writeback_mask,
    input  logic                      wb_rollback_en,
    input  thread_idx_t               wb_rollback_thread_idx,
    output logic                      of_instruction_valid,
    output decoded_instruction_t      of_instruction,
    output thread_idx_t               of_thread_idx,
    output subcycle_t                 of_subcycle,
    output logic [32*NUM_LANES-1:0]   of_operand1,
    output logic [32*NUM_LANES-1:0]   of_operand2,
    output logic [NUM_LANES-1:0]      of_mask_value,
    output logic [32*NUM_LANES-1:0]   of_store_value
);
    localparam int LW    = 32 * NUM_LANES;
    localparam int DEPTH = THREADS * NUM_REGISTERS;
    localparam int TW    = $clog2(THREADS);
    localparam int RW    = $clog2(NUM_REGISTERS);
    localparam int AW    = TW + RW;
    localparam register_idx_t PC_REG = register_idx_t'(NUM_REGISTERS - 1);

    logic [AW-1:0] s1_addr, s2_addr, v1_addr, v2_addr, wr_addr;

    assign s1_addr = {ts_thread_idx[TW-1:0], ts_instruction.scalar_sel1[RW-1:0]};
    assign s2_addr = {ts_thread_idx[TW-1:0], ts_instruction.scalar_sel2[RW-1:0]};
    assign v1_addr = {ts_thread_idx[TW-1:0], ts_instruction.vector_sel1[RW-1:0]};
    assign v2_addr = {ts_thread_idx[TW-1:0], ts_instruction.vector_sel2[RW-1:0]};
    assign wr_addr = {wb_writeback_thread_idx[TW-1:0], wb_writeback_reg[RW-1:0]};

    // Scalar file: two read ports, read-first against the shared write port.
    logic [31:0] scalar_rf [DEPTH];
    logic [31:0] s1_rdata_q, s2_rdata_q;

    always_ff @(posedge clk) begin
        if (wb_writeback_en && !wb_writeback_is_vector)
            scalar_rf[wr_addr] <= wb_writeback_value[31:0];
        if (reset) begin
            s1_rdata_q <= '0;
            s2_rdata_q <= '0;
        end else begin
            s1_rdata_q <= scalar_rf[s1_addr];
            s2_rdata_q <= scalar_rf[s2_addr];
        end
    end

    // Vector file is split per lane so each lane's write enable is its mask bit.
    logic [LW-1:0] v1_rdata, v2_rdata;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_vlane
            logic [31:0] lane_rf [DEPTH];
            logic [31:0] v1_lane_q, v2_lane_q;

            always_ff @(posedge clk) begin
                if (wb_writeback_en && wb_writeback_is_vector && wb_writeback_mask[gi])
                    lane_rf[wr_addr] <= wb_writeback_value[gi*32 +: 32];
                if (reset) begin
                    v1_lane_q <= '0;
                    v2_lane_q <= '0;
                end else begin
                    v1_lane_q <= lane_rf[v1_addr];
                    v2_lane_q <= lane_rf[v2_addr];
                end
            end

            assign v1_rdata[gi*32 +: 32] = v1_lane_q;
            assign v2_rdata[gi*32 +: 32] = v2_lane_q;
        end
    endgenerate

    logic                 valid_d, valid_q;
    decoded_instruction_t instr_d, instr_q;
    thread_idx_t          thread_d, thread_q;
    subcycle_t            subcycle_d, subcycle_q;
    logic [31:0]          pc_plus4_d, pc_plus4_q;
    logic                 s1_is_pc_d, s1_is_pc_q;
    logic                 s2_is_pc_d, s2_is_pc_q;

    always_comb begin
        valid_d    = ts_instruction_valid
                     && !(wb_rollback_en && wb_rollback_thread_idx == ts_thread_idx);
        instr_d    = ts_instruction;
        thread_d   = ts_thread_idx;
        subcycle_d = ts_subcycle;
        pc_plus4_d = ts_instruction.pc + 32'd4;
        s1_is_pc_d = ts_instruction.scalar_sel1 == PC_REG;
        s2_is_pc_d = ts_instruction.scalar_sel2 == PC_REG;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            instr_q    <= '0;
            thread_q   <= '0;
            subcycle_q <= '0;
            pc_plus4_q <= '0;
            s1_is_pc_q <= 1'b0;
            s2_is_pc_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            thread_q   <= thread_d;
            subcycle_q <= subcycle_d;
            pc_plus4_q <= pc_plus4_d;
            s1_is_pc_q <= s1_is_pc_d;
            s2_is_pc_q <= s2_is_pc_d;
        end
    end

    // The stored s31 value is never visible; PC reads substitute pc + 4.
    logic [31:0] scalar1, scalar2;

    always_comb begin
        scalar1 = s1_is_pc_q ? pc_plus4_q : s1_rdata_q;
        scalar2 = s2_is_pc_q ? pc_plus4_q : s2_rdata_q;

        of_operand1 = instr_q.op1_is_vector ? v1_rdata : {NUM_LANES{scalar1}};

        case (instr_q.op2_src)
            OP2_VECTOR2:   of_operand2 = v2_rdata;
            OP2_IMMEDIATE: of_operand2 = {NUM_LANES{instr_q.immediate_value}};
            default:       of_operand2 = {NUM_LANES{scalar2}};
        endcase

        case (instr_q.mask_src)
            MASK_SCALAR1: of_mask_value = scalar1[NUM_LANES-1:0];
            MASK_SCALAR2: of_mask_value = scalar2[NUM_LANES-1:0];
            default:      of_mask_value = '1;
        endcase

        of_store_value = instr_q.store_value_is_vector ? v2_rdata : {NUM_LANES{scalar2}};
    end

    assign of_instruction_valid = valid_q;
    assign of_instruction       = instr_q;
    assign of_thread_idx        = thread_q;
    assign of_subcycle          = subcycle_q;
endmodule
